// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared core-wide sizing constants (physical register file
//                index width, reorder-buffer depth).
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  localparam int PHYS_REG_FILE_IDX_BW = 6;
  localparam int ROB_DEPTH            = 16;

endpackage
`default_nettype wire

// File: rtl/rv32i_mult_rsv_station.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_mult_rsv_station
//  Description : Reservation station for the multiplier. Entries live in a
//                collapsing age queue (index 0 oldest). Sources wake up from
//                the CDB; the oldest entry with both operands ready is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_mult_rsv_station
  import rv32i_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int TAG_W = PHYS_REG_FILE_IDX_BW,
  localparam int ROB_W = $clog2(ROB_DEPTH),
  localparam int IDX_W = $clog2(DEPTH),
  localparam int OCC_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rstn,
  // dispatch
  input  logic             i_disp_vld,
  output logic             o_disp_rdy,
  input  logic [TAG_W-1:0] i_disp_src1_tag,
  input  logic [TAG_W-1:0] i_disp_src2_tag,
  input  logic             i_disp_src1_rdy,
  input  logic             i_disp_src2_rdy,
  input  logic [31:0]      i_disp_src1_val,
  input  logic [31:0]      i_disp_src2_val,
  input  logic [TAG_W-1:0] i_disp_dst_phys_rf_tag,
  input  logic [ROB_W-1:0] i_disp_rob_entry_idx,
  // common data bus
  input  logic             i_cdb_vld,
  input  logic [TAG_W-1:0] i_cdb_tag,
  input  logic [31:0]      i_cdb_data,
  // pipeline flush
  input  logic             i_flush,
  // issue to multiplier
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [31:0]      o_multiplicand,
  output logic [31:0]      o_multiplier,
  output logic [TAG_W-1:0] o_dst_phys_rf_tag,
  output logic [ROB_W-1:0] o_rob_entry_idx,
  output logic [OCC_W-1:0] o_occupancy
);

  localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(DEPTH);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_rdy;
    logic [31:0]      s1_val;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_rdy;
    logic [31:0]      s2_val;
    logic [TAG_W-1:0] dst;
    logic [ROB_W-1:0] rob;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Woken copy of every entry; the extra slot at DEPTH is an empty entry
  // that the top of the queue collapses onto during an issue.
  entry_t           w_wake [DEPTH+1];
  entry_t           w_new;
  logic             w_any_elig;
  logic [IDX_W-1:0] w_sel;
  logic             w_issue;
  logic             w_disp;
  logic [OCC_W-1:0] w_wr_idx;

  assign o_disp_rdy  = (occ_q < C_DEPTH) && !i_flush;
  assign o_vld       = w_any_elig && !i_flush;
  assign o_occupancy = occ_q;
  assign w_issue     = o_vld && i_rdy;
  assign w_disp      = i_disp_vld && o_disp_rdy;
  // An issue in the same cycle collapses the queue, so the new entry lands one lower.
  assign w_wr_idx    = w_issue ? (occ_q - 1'b1) : occ_q;

  // Oldest-first select among entries whose both sources are already registered ready.
  always_comb begin
    w_any_elig = 1'b0;
    w_sel      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].vld && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        w_any_elig = 1'b1;
        w_sel      = IDX_W'(i);
      end
    end
  end

  // Capture CDB results into waiting sources of valid entries.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wake[i] = ent_q[i];
      if (i_cdb_vld && ent_q[i].vld) begin
        if (!ent_q[i].s1_rdy && (ent_q[i].s1_tag == i_cdb_tag)) begin
          w_wake[i].s1_rdy = 1'b1;
          w_wake[i].s1_val = i_cdb_data;
        end
        if (!ent_q[i].s2_rdy && (ent_q[i].s2_tag == i_cdb_tag)) begin
          w_wake[i].s2_rdy = 1'b1;
          w_wake[i].s2_val = i_cdb_data;
        end
      end
    end
    w_wake[DEPTH] = '0;
  end

  // Build the dispatched entry, bypassing a CDB result broadcast in the same cycle.
  always_comb begin
    w_new        = '0;
    w_new.vld    = 1'b1;
    w_new.s1_tag = i_disp_src1_tag;
    w_new.s1_rdy = i_disp_src1_rdy;
    w_new.s1_val = i_disp_src1_val;
    w_new.s2_tag = i_disp_src2_tag;
    w_new.s2_rdy = i_disp_src2_rdy;
    w_new.s2_val = i_disp_src2_val;
    w_new.dst    = i_disp_dst_phys_rf_tag;
    w_new.rob    = i_disp_rob_entry_idx;
    if (i_cdb_vld && !i_disp_src1_rdy && (i_disp_src1_tag == i_cdb_tag)) begin
      w_new.s1_rdy = 1'b1;
      w_new.s1_val = i_cdb_data;
    end
    if (i_cdb_vld && !i_disp_src2_rdy && (i_disp_src2_tag == i_cdb_tag)) begin
      w_new.s2_rdy = 1'b1;
      w_new.s2_val = i_cdb_data;
    end
  end

  // Next queue contents: collapse above the issued slot, append dispatch, flush kills all.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_issue && (i >= int'(w_sel))) begin
        ent_d[i] = w_wake[i+1];
      end else begin
        ent_d[i] = w_wake[i];
      end
      if (w_disp && (OCC_W'(i) == w_wr_idx)) begin
        ent_d[i] = w_new;
      end
      if (i_flush) begin
        ent_d[i].vld = 1'b0;
      end
    end
  end

  // Occupancy tracks dispatches minus issues; a flush empties the station.
  always_comb begin
    occ_d = occ_q;
    if (i_flush) begin
      occ_d = '0;
    end else if (w_disp && !w_issue) begin
      occ_d = occ_q + 1'b1;
    end else if (!w_disp && w_issue) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Issue payload comes straight from the selected entry and is zeroed when idle.
  always_comb begin
    o_multiplicand    = '0;
    o_multiplier      = '0;
    o_dst_phys_rf_tag = '0;
    o_rob_entry_idx   = '0;
    if (o_vld) begin
      o_multiplicand    = ent_q[w_sel].s1_val;
      o_multiplier      = ent_q[w_sel].s2_val;
      o_dst_phys_rf_tag = ent_q[w_sel].dst;
      o_rob_entry_idx   = ent_q[w_sel].rob;
    end
  end

  // Entry and occupancy registers; reset discards everything immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      occ_q <= occ_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mult_rsv_station.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_mult_rsv_station
//  Description : Self-checking bench: directed cycle table, asynchronous
//                reset check, then random traffic against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_mult_rsv_station;
  import rv32i_pkg::*;

  localparam int TAG_W = PHYS_REG_FILE_IDX_BW;
  localparam int ROB_W = $clog2(ROB_DEPTH);
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int NVEC  = 34;

  logic             clk = 1'b0;
  logic             rstn;
  logic             i_disp_vld;
  logic             o_disp_rdy;
  logic [TAG_W-1:0] i_disp_src1_tag, i_disp_src2_tag;
  logic             i_disp_src1_rdy, i_disp_src2_rdy;
  logic [31:0]      i_disp_src1_val, i_disp_src2_val;
  logic [TAG_W-1:0] i_disp_dst_phys_rf_tag;
  logic [ROB_W-1:0] i_disp_rob_entry_idx;
  logic             i_cdb_vld;
  logic [TAG_W-1:0] i_cdb_tag;
  logic [31:0]      i_cdb_data;
  logic             i_flush;
  logic             o_vld;
  logic             i_rdy;
  logic [31:0]      o_multiplicand, o_multiplier;
  logic [TAG_W-1:0] o_dst_phys_rf_tag;
  logic [ROB_W-1:0] o_rob_entry_idx;
  logic [OCC_W-1:0] o_occupancy;

  rv32i_mult_rsv_station #(.DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .i_disp_vld             (i_disp_vld),
    .o_disp_rdy             (o_disp_rdy),
    .i_disp_src1_tag        (i_disp_src1_tag),
    .i_disp_src2_tag        (i_disp_src2_tag),
    .i_disp_src1_rdy        (i_disp_src1_rdy),
    .i_disp_src2_rdy        (i_disp_src2_rdy),
    .i_disp_src1_val        (i_disp_src1_val),
    .i_disp_src2_val        (i_disp_src2_val),
    .i_disp_dst_phys_rf_tag (i_disp_dst_phys_rf_tag),
    .i_disp_rob_entry_idx   (i_disp_rob_entry_idx),
    .i_cdb_vld              (i_cdb_vld),
    .i_cdb_tag              (i_cdb_tag),
    .i_cdb_data             (i_cdb_data),
    .i_flush                (i_flush),
    .o_vld                  (o_vld),
    .i_rdy                  (i_rdy),
    .o_multiplicand         (o_multiplicand),
    .o_multiplier           (o_multiplier),
    .o_dst_phys_rf_tag      (o_dst_phys_rf_tag),
    .o_rob_entry_idx        (o_rob_entry_idx),
    .o_occupancy            (o_occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             dv;
    logic [TAG_W-1:0] t1;
    logic             r1;
    logic [31:0]      v1;
    logic [TAG_W-1:0] t2;
    logic             r2;
    logic [31:0]      v2;
    logic [TAG_W-1:0] dst;
    logic [ROB_W-1:0] rob;
    logic             cv;
    logic [TAG_W-1:0] ct;
    logic [31:0]      cd;
    logic             fl;
    logic             rdy;
    logic             ev;
    logic             edr;
    logic [OCC_W-1:0] eocc;
    logic [31:0]      emc;
    logic [31:0]      emp;
    logic [TAG_W-1:0] edst;
    logic [ROB_W-1:0] erob;
  } vec_t;

  typedef struct packed {
    logic [TAG_W-1:0] t1;
    logic             r1;
    logic [31:0]      v1;
    logic [TAG_W-1:0] t2;
    logic             r2;
    logic [31:0]      v2;
    logic [TAG_W-1:0] dst;
    logic [ROB_W-1:0] rob;
  } ment_t;

  int    checks   = 0;
  int    failures = 0;
  vec_t  tbl [NVEC];
  ment_t q [$];

  function automatic vec_t mk(int dv, int t1, int r1, int v1, int t2, int r2, int v2,
                              int dst, int rob, int cv, int ct, int cd, int fl, int rdy,
                              int ev, int edr, int eocc, int emc, int emp, int edst, int erob);
    vec_t v;
    v.dv = 1'(dv);   v.t1 = TAG_W'(t1); v.r1 = 1'(r1); v.v1 = 32'(v1);
    v.t2 = TAG_W'(t2); v.r2 = 1'(r2); v.v2 = 32'(v2);
    v.dst = TAG_W'(dst); v.rob = ROB_W'(rob);
    v.cv = 1'(cv);   v.ct = TAG_W'(ct); v.cd = 32'(cd);
    v.fl = 1'(fl);   v.rdy = 1'(rdy);
    v.ev = 1'(ev);   v.edr = 1'(edr); v.eocc = OCC_W'(eocc);
    v.emc = 32'(emc); v.emp = 32'(emp); v.edst = TAG_W'(edst); v.erob = ROB_W'(erob);
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    i_disp_vld = v.dv;
    i_disp_src1_tag = v.t1; i_disp_src1_rdy = v.r1; i_disp_src1_val = v.v1;
    i_disp_src2_tag = v.t2; i_disp_src2_rdy = v.r2; i_disp_src2_val = v.v2;
    i_disp_dst_phys_rf_tag = v.dst; i_disp_rob_entry_idx = v.rob;
    i_cdb_vld = v.cv; i_cdb_tag = v.ct; i_cdb_data = v.cd;
    i_flush = v.fl; i_rdy = v.rdy;
  endtask

  task automatic chk_out(string pfx, logic ev, logic edr, logic [OCC_W-1:0] eocc,
                         logic [31:0] emc, logic [31:0] emp,
                         logic [TAG_W-1:0] edst, logic [ROB_W-1:0] erob);
    chk({pfx, " o_vld"},       32'(o_vld),             32'(ev));
    chk({pfx, " o_disp_rdy"},  32'(o_disp_rdy),        32'(edr));
    chk({pfx, " occupancy"},   32'(o_occupancy),       32'(eocc));
    chk({pfx, " multiplicand"}, o_multiplicand,         emc);
    chk({pfx, " multiplier"},  o_multiplier,           emp);
    chk({pfx, " dst"},         32'(o_dst_phys_rf_tag), 32'(edst));
    chk({pfx, " rob"},         32'(o_rob_entry_idx),   32'(erob));
  endtask

  initial begin
    vec_t  v;
    ment_t e;
    int    k;
    logic  ev, edr;

    // Directed cycle table: inputs of a cycle and the outputs expected during it.
    // basic ready-ready issue
    tbl[0]  = mk(1,1,1,7,   2,1,6,   5,2,   0,0,0,     0,1, 0,1,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 1,1,1,7,6,5,2);
    tbl[2]  = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 0,1,0,0,0,0,0);
    // wake-up two cycles after dispatch
    tbl[3]  = mk(1,3,1,2,   9,0,0,   4,3,   0,0,0,     0,1, 0,1,0,0,0,0,0);
    tbl[4]  = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 0,1,1,0,0,0,0);
    tbl[5]  = mk(0,0,0,0,   0,0,0,   0,0,   1,9,'h10,  0,1, 0,1,1,0,0,0,0);
    tbl[6]  = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 1,1,1,2,'h10,4,3);
    tbl[7]  = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 0,1,0,0,0,0,0);
    // dispatch/CDB bypass
    tbl[8]  = mk(1,9,0,0,   10,1,5,  6,4,   1,9,3,     0,1, 0,1,0,0,0,0,0);
    tbl[9]  = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 1,1,1,3,5,6,4);
    tbl[10] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,0, 0,1,0,0,0,0,0);
    // fill, reject fifth, drain in order
    tbl[11] = mk(1,1,1,1,   2,1,11,  8,8,   0,0,0,     0,0, 0,1,0,0,0,0,0);
    tbl[12] = mk(1,1,1,2,   2,1,12,  9,9,   0,0,0,     0,0, 1,1,1,1,11,8,8);
    tbl[13] = mk(1,1,1,3,   2,1,13,  10,10, 0,0,0,     0,0, 1,1,2,1,11,8,8);
    tbl[14] = mk(1,1,1,4,   2,1,14,  11,11, 0,0,0,     0,0, 1,1,3,1,11,8,8);
    tbl[15] = mk(1,1,1,5,   2,1,15,  12,12, 0,0,0,     0,0, 1,0,4,1,11,8,8);
    tbl[16] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 1,0,4,1,11,8,8);
    tbl[17] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,0, 1,1,3,2,12,9,9);
    tbl[18] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 1,1,3,2,12,9,9);
    tbl[19] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 1,1,2,3,13,10,10);
    tbl[20] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 1,1,1,4,14,11,11);
    tbl[21] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,0, 0,1,0,0,0,0,0);
    // younger ready entry overtakes a waiting older one
    tbl[22] = mk(1,20,0,0,  2,1,7,   1,1,   0,0,0,     0,0, 0,1,0,0,0,0,0);
    tbl[23] = mk(1,1,1,8,   2,1,9,   2,2,   0,0,0,     0,0, 0,1,1,0,0,0,0);
    tbl[24] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 1,1,2,8,9,2,2);
    tbl[25] = mk(0,0,0,0,   0,0,0,   0,0,   1,20,'h55, 0,0, 0,1,1,0,0,0,0);
    tbl[26] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 1,1,1,'h55,7,1,1);
    tbl[27] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,0, 0,1,0,0,0,0,0);
    // flush beats dispatch, issue and wake-up
    tbl[28] = mk(1,30,0,0,  2,1,1,   3,3,   0,0,0,     0,0, 0,1,0,0,0,0,0);
    tbl[29] = mk(1,1,1,1,   2,1,2,   4,4,   0,0,0,     0,0, 0,1,1,0,0,0,0);
    tbl[30] = mk(1,1,1,3,   2,1,4,   5,5,   0,0,0,     0,0, 1,1,2,1,2,4,4);
    tbl[31] = mk(1,1,1,9,   2,1,9,   7,7,   1,30,1,    1,1, 0,0,3,0,0,0,0);
    tbl[32] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,1, 0,1,0,0,0,0,0);
    tbl[33] = mk(0,0,0,0,   0,0,0,   0,0,   0,0,0,     0,0, 0,1,0,0,0,0,0);

    // Reset state
    rstn = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    chk_out("reset", 1'b0, 1'b1, '0, '0, '0, '0, '0);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].edr, tbl[i].eocc,
              tbl[i].emc, tbl[i].emp, tbl[i].edst, tbl[i].erob);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a cycle with a live entry
    drive(mk(1,1,1,'h11, 2,1,'h22, 1,1, 0,0,0, 0,0, 0,0,0,0,0,0,0));
    @(posedge clk); #1;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    chk_out("pre_areset", 1'b1, 1'b1, OCC_W'(1), 32'h11, 32'h22, TAG_W'(1), ROB_W'(1));
    #2 rstn = 1'b0;
    #1;
    chk_out("areset", 1'b0, 1'b1, '0, '0, '0, '0, '0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Random traffic against an ordered-queue model of the station
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v = mk(($urandom_range(0, 9) < 7) ? 1 : 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
             ($urandom_range(0, 9) < 4) ? 1 : 0, int'($urandom_range(0, 7)), int'($urandom),
             ($urandom_range(0, 49) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
             0,0,0,0,0,0,0);
      drive(v);
      @(negedge clk);
      k = -1;
      for (int j = 0; j < q.size(); j++) begin
        if (q[j].r1 && q[j].r2) begin
          k = j;
          break;
        end
      end
      ev  = (k >= 0) && !v.fl;
      edr = (q.size() < DEPTH) && !v.fl;
      if (ev)
        chk_out($sformatf("rnd%0d", cyc), 1'b1, edr, OCC_W'(q.size()),
                q[k].v1, q[k].v2, q[k].dst, q[k].rob);
      else
        chk_out($sformatf("rnd%0d", cyc), 1'b0, edr, OCC_W'(q.size()), '0, '0, '0, '0);
      @(posedge clk);
      if (v.fl) begin
        q.delete();
      end else begin
        if (ev && v.rdy) q.delete(k);
        if (v.cv) begin
          for (int j = 0; j < q.size(); j++) begin
            if (!q[j].r1 && q[j].t1 == v.ct) begin q[j].r1 = 1'b1; q[j].v1 = v.cd; end
            if (!q[j].r2 && q[j].t2 == v.ct) begin q[j].r2 = 1'b1; q[j].v2 = v.cd; end
          end
        end
        if (v.dv && edr) begin
          e.t1 = v.t1; e.r1 = v.r1; e.v1 = v.v1;
          e.t2 = v.t2; e.r2 = v.r2; e.v2 = v.v2;
          e.dst = v.dst; e.rob = v.rob;
          if (v.cv && !e.r1 && e.t1 == v.ct) begin e.r1 = 1'b1; e.v1 = v.cd; end
          if (v.cv && !e.r2 && e.t2 == v.ct) begin e.r2 = 1'b1; e.v2 = v.cd; end
          q.push_back(e);
        end
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
